// File: rtl/axi2mem_busy_pkg.sv
// Shared types and defaults for the axi2mem outstanding-transaction tracker.
package axi2mem_busy_pkg;

    // Drain/quiesce handshake states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } drain_state_e;

    // Default width of each per-port outstanding counter.
    localparam int unsigned DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/axi2mem_busy_tracker_if.sv
// Sync-pulse inputs and status outputs of the busy tracker, grouped per side.
interface axi2mem_busy_tracker_if #(
    parameter int unsigned NUM_PORTS = 1
) ();

    logic [NUM_PORTS-1:0] aw_sync_i;
    logic [NUM_PORTS-1:0] b_sync_i;
    logic [NUM_PORTS-1:0] ar_sync_i;
    logic [NUM_PORTS-1:0] r_sync_i;
    logic                 drain_req_i;
    logic                 err_clear_i;
    logic                 busy_o;
    logic [NUM_PORTS-1:0] port_busy_o;
    logic [NUM_PORTS-1:0] aw_stall_o;
    logic [NUM_PORTS-1:0] ar_stall_o;
    logic                 drain_ack_o;
    logic                 err_overflow_o;
    logic                 err_underflow_o;

    // Tracker side.
    modport slave (
        input  aw_sync_i, b_sync_i, ar_sync_i, r_sync_i, drain_req_i, err_clear_i,
        output busy_o, port_busy_o, aw_stall_o, ar_stall_o, drain_ack_o,
        output err_overflow_o, err_underflow_o
    );

    // Channel-unit / power-control side.
    modport master (
        output aw_sync_i, b_sync_i, ar_sync_i, r_sync_i, drain_req_i, err_clear_i,
        input  busy_o, port_busy_o, aw_stall_o, ar_stall_o, drain_ack_o,
        input  err_overflow_o, err_underflow_o
    );

endinterface

// File: rtl/axi2mem_busy_counter.sv
// One saturating up/down outstanding counter with limit and error-event flags.
module axi2mem_busy_counter #(
    parameter int unsigned CNT_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = (2**CNT_WIDTH) - 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 nonzero_o,
    output logic                 at_limit_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0] count_q;
    logic                 inc_only;
    logic                 dec_only;

    assign inc_only = inc_i & ~dec_i;
    assign dec_only = dec_i & ~inc_i;

    // Simultaneous issue and retire cancel; saturate at both ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_only && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end else if (dec_only && (count_q != '0)) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    assign count_o     = count_q;
    assign nonzero_o   = (count_q != '0);
    assign at_limit_o  = (count_q >= LIMIT);
    assign overflow_o  = inc_only & (count_q == CNT_MAX);
    assign underflow_o = dec_only & (count_q == '0);

endmodule

// File: rtl/axi2mem_busy_tracker.sv
// Outstanding-transaction tracker: per-port write/read counters, busy/stall
// aggregation and the drain/quiesce handshake.
// Optional: define AXI2MEM_BUSY_ERR_EN for sticky overflow/underflow flags.
module axi2mem_busy_tracker
    import axi2mem_busy_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 1,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = (2**CNT_WIDTH) - 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi2mem_busy_tracker_if.slave  bus
);

    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] wcnt;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] rcnt;
    logic [NUM_PORTS-1:0] w_nz, r_nz, w_lim, r_lim;
    logic [NUM_PORTS-1:0] w_ovf, w_unf, r_ovf, r_unf;
    logic                 all_idle;
    logic                 any_issue;
    drain_state_e         state_q;

    // One write and one read counter per port.
    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
        axi2mem_busy_counter #(
            .CNT_WIDTH       (CNT_WIDTH),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_wcnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (bus.aw_sync_i[p]),
            .dec_i       (bus.b_sync_i[p]),
            .count_o     (wcnt[p]),
            .nonzero_o   (w_nz[p]),
            .at_limit_o  (w_lim[p]),
            .overflow_o  (w_ovf[p]),
            .underflow_o (w_unf[p])
        );

        axi2mem_busy_counter #(
            .CNT_WIDTH       (CNT_WIDTH),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_rcnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (bus.ar_sync_i[p]),
            .dec_i       (bus.r_sync_i[p]),
            .count_o     (rcnt[p]),
            .nonzero_o   (r_nz[p]),
            .at_limit_o  (r_lim[p]),
            .overflow_o  (r_ovf[p]),
            .underflow_o (r_unf[p])
        );
    end

    // Raw counts are only observed through the derived flags.
    logic unused_cnt;
    assign unused_cnt = ^{wcnt, rcnt};

    assign all_idle  = ~|{w_nz, r_nz};
    assign any_issue = (|bus.aw_sync_i) | (|bus.ar_sync_i);

    // Drain FSM; an issue while quiesced drops back to DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.drain_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.drain_req_i) state_q <= RUN;
                    else if (all_idle)    state_q <= QUIESCED;
                end
                QUIESCED: begin
                    if (!bus.drain_req_i) state_q <= RUN;
                    else if (any_issue)   state_q <= DRAIN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.busy_o      = ~all_idle;
    assign bus.port_busy_o = w_nz | r_nz;
    assign bus.aw_stall_o  = w_lim | {NUM_PORTS{state_q != RUN}};
    assign bus.ar_stall_o  = r_lim | {NUM_PORTS{state_q != RUN}};
    assign bus.drain_ack_o = (state_q == QUIESCED);

`ifdef AXI2MEM_BUSY_ERR_EN
    logic err_ovf_q;
    logic err_unf_q;

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (|{w_ovf, r_ovf})      err_ovf_q <= 1'b1;
            else if (bus.err_clear_i) err_ovf_q <= 1'b0;
            if (|{w_unf, r_unf})      err_unf_q <= 1'b1;
            else if (bus.err_clear_i) err_unf_q <= 1'b0;
        end
    end

    assign bus.err_overflow_o  = err_ovf_q;
    assign bus.err_underflow_o = err_unf_q;
`else
    logic unused_err;
    assign unused_err = ^{w_ovf, w_unf, r_ovf, r_unf, bus.err_clear_i};

    assign bus.err_overflow_o  = 1'b0;
    assign bus.err_underflow_o = 1'b0;
`endif

endmodule

// File: doc/axi2mem_busy_tracker.md
# axi2mem_busy_tracker

Parametrised outstanding-transaction tracker for the axi2mem bridge. It keeps one saturating up/down counter per port for writes (AW issue / B retire) and one for reads (AR issue / R-last retire), and derives aggregate and per-port busy. It stalls ports that reach the outstanding limit and provides a drain/quiesce handshake used by power and clock gating control. It sits beside the axi2mem channel units, fed by their single-cycle sync pulses.

## Interface
- NUM_PORTS, default 1: number of independent AXI slave ports tracked.
- CNT_WIDTH, default 4: width of each outstanding counter.
- MAX_OUTSTANDING, default 2**CNT_WIDTH-1: stall threshold, 1..2**CNT_WIDTH-1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- aw_sync_i  in  NUM_PORTS  write issue pulse per port.
- b_sync_i  in  NUM_PORTS  write retire pulse per port.
- ar_sync_i  in  NUM_PORTS  read issue pulse per port.
- r_sync_i  in  NUM_PORTS  read retire pulse per port (last beat).
- drain_req_i  in  1  level request to block new transactions and quiesce.
- err_clear_i  in  1  clears sticky error flags.
- busy_o  out  1  any counter non-zero.
- port_busy_o  out  NUM_PORTS  that port's write or read counter non-zero.
- aw_stall_o  out  NUM_PORTS  port must not issue a new AW.
- ar_stall_o  out  NUM_PORTS  port must not issue a new AR.
- drain_ack_o  out  1  drained; all counters zero while drain requested.
- err_overflow_o  out  1  sticky: issue seen at saturated count.
- err_underflow_o  out  1  sticky: retire seen at zero count.

## Operation
- Counter update per port and direction, evaluated each cycle:
  - issue only: +1.
  - retire only: -1.
  - both or neither: hold, with no net change even when the count is 0 or saturated.
- Saturation: issue-only at 2**CNT_WIDTH-1 holds the count and sets overflow. Retire-only at 0 holds at 0 and sets underflow.
- Stall: aw_stall_o[p] = (wcnt[p] >= MAX_OUTSTANDING) or state != RUN. ar_stall_o follows the same rule on rcnt[p].
- Stall is advisory. Syncs that arrive while stalled are still counted.
- Drain FSM:
  - RUN: drain_req_i=1 -> DRAIN.
  - DRAIN: drain_req_i=0 -> RUN. All counters zero -> QUIESCED.
  - QUIESCED: drain_ack_o=1. drain_req_i=0 -> RUN. Any issue pulse -> DRAIN (protocol violation, also counted).
- Error flags: set on the events above. err_clear_i clears them. If set and clear coincide, set wins.

## Timing
- Reset values:
  - all counters 0, state RUN.
  - busy_o=0, port_busy_o=0, stalls=0, drain_ack_o=0, errors=0.
- Counters are registered. busy_o, port_busy_o and the stall outputs are combinational from registered counters and state, so they reflect a sync one cycle after the pulse.
- drain_ack_o is decoded from the registered state. It rises one cycle after the edge on which the last counter reaches zero, i.e. two cycles after the final retire pulse when drain_req_i is already high.
- Stall asserts the cycle after the issue that reaches MAX_OUTSTANDING. It releases the cycle after the retire that drops the count below it.
- With drain_req_i high in RUN, stalls assert on the following cycle.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of outstanding transactions.

## Configuration
- AXI2MEM_BUSY_ERR_EN defined: overflow/underflow detection and the sticky flags are implemented.
- Not defined:
  - err_overflow_o and err_underflow_o are tied to 0 and err_clear_i is ignored.
  - Saturation and zero-hold behaviour is unchanged.

## Structure
- Package axi2mem_busy_pkg holds:
  - drain_state_e {RUN, DRAIN, QUIESCED}.
  - the default CNT_WIDTH constant.
- Sub-module axi2mem_busy_counter: one saturating up/down counter.
  - Parameters: CNT_WIDTH, MAX_OUTSTANDING.
  - Outputs: count, nonzero, at_limit, overflow pulse, underflow pulse.
  - Instantiated 2*NUM_PORTS times.
- The top level holds the FSM, aggregation and sticky flags.

## Test plan
- NUM_PORTS=2, CNT_WIDTH=4: 3 AW pulses on port 1, then 3 B pulses -> port_busy_o=2'b10 and busy_o=1 from cycle 1 after the first AW to 1 cycle after the last B, then 0.
- MAX_OUTSTANDING=4: 4 AR pulses on port 0 -> ar_stall_o[0]=1 the cycle after the 4th. One R pulse -> stall 0 the next cycle. Simultaneous AR+R at count 4 -> count stays 4, stall stays 1.
- Count 15 (CNT_WIDTH=4) plus AW-only -> count holds 15, err_overflow_o=1. B at count 0 -> err_underflow_o=1. err_clear_i -> both 0 next cycle, unless a new error event occurs in the same cycle.
- 2 writes outstanding, drain_req_i=1 -> all stalls 1 next cycle. Retire both -> drain_ack_o=1 two cycles after the last B. Drop drain_req_i -> ack and stalls 0 next cycle.
- Assert rst_ni low with 5 reads outstanding and in DRAIN -> all outputs 0 immediately. After release, state RUN and counts 0.
- Build without AXI2MEM_BUSY_ERR_EN, repeat the overflow case -> error outputs stay 0 and the count still saturates at 15.
